// File: rtl/ysyx_23060020_wbu.sv
// Writeback unit: arbitrates EXU/LSU results onto the single register-file
// write port and tracks per-register pending writes for RAW hazard detection.
module ysyx_23060020_wbu #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CNTW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  // EXU result channel
  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic [4:0]      exu_rd,
  input  logic [XLEN-1:0] exu_data,
  // LSU load result channel
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  // register-file write port
  output logic            rfwen,
  output logic [4:0]      w1a,
  output logic [XLEN-1:0] w1d,
  // scoreboard issue/query
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [31:0]     wb_cnt
);

  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;
  localparam logic [CNTW-1:0] CNT_MAX  = '1;
  localparam logic [CNTW-1:0] CNT_ZERO = '0;

  logic            accept;
  logic [AW-1:0]   acc_rd;
  logic [XLEN-1:0] acc_data;
  logic            issue_fire;

  logic [CNTW-1:0] cnt_q    [1:NREG-1];
  logic [CNTW-1:0] cnt_view [NREG];
  logic [NREG-1:1] inc_vec;
  logic [NREG-1:1] dec_vec;

  // LSU has fixed priority; it is always accepted, EXU only when LSU is idle
  assign lsu_ready = 1'b1;
  assign exu_ready = !lsu_valid;

  // Select the winning result for this cycle
  always_comb begin
    accept   = 1'b0;
    acc_rd   = '0;
    acc_data = '0;
    if (lsu_valid) begin
      accept   = 1'b1;
      acc_rd   = lsu_rd;
      acc_data = lsu_data;
    end else if (exu_valid) begin
      accept   = 1'b1;
      acc_rd   = exu_rd;
      acc_data = exu_data;
    end
  end

  // Register the write port; address/data hold when nothing is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rfwen  <= 1'b0;
      w1a    <= '0;
      w1d    <= '0;
      wb_cnt <= '0;
    end else begin
      rfwen <= 1'b0;
      if (accept) begin
        rfwen  <= (acc_rd != '0);
        w1a    <= acc_rd;
        w1d    <= acc_data;
        wb_cnt <= wb_cnt + 32'd1;
      end
    end
  end

  // Flat view of the counters with x0 hard-wired to zero
  always_comb begin
    cnt_view[0] = CNT_ZERO;
    for (int i = 1; i < NREG; i++) begin
      cnt_view[i] = cnt_q[i];
    end
  end

  // Combinational scoreboard queries; a same-cycle retire is not visible here
  assign issue_ready = (issue_rd == '0) || (cnt_view[issue_rd] != CNT_MAX);
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);
  assign rs1_busy    = (cnt_view[rs1] != CNT_ZERO);
  assign rs2_busy    = (cnt_view[rs2] != CNT_ZERO);

  // Per-register increment on issue and decrement on register-file commit
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 1; i < NREG; i++) begin
      inc_vec[i] = issue_fire && (issue_rd == AW'(i));
      dec_vec[i] = rfwen && (w1a == AW'(i));
    end
  end

  // Pending counters; a decrement at zero is a protocol error and holds at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          cnt_q[i] <= cnt_q[i] + CNTW'(1);
        end else if (dec_vec[i] && !inc_vec[i] && (cnt_q[i] != CNT_ZERO)) begin
          cnt_q[i] <= cnt_q[i] - CNTW'(1);
        end
      end
    end
  end

endmodule

// File: doc/ysyx_23060020_wbu.md
# ysyx_23060020_wbu

Writeback unit for the ysyx_23060020 core. It accepts completed results from the execute unit (EXU) and the load/store unit (LSU) over valid/ready handshakes and arbitrates them to a single register-file write port. It drives that port (rfwen/w1a/w1d) from registered outputs. It also keeps a per-register pending-write scoreboard, which the decode unit queries for RAW stalls and updates on issue.

## Interface
Parameters:
- XLEN, 32, data width of results and of w1d.
- CNTW, 2, width of each per-register pending counter; maximum pending count is 2^CNTW-1.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- exu_valid  in  1  EXU result valid.
- exu_ready  out  1  WBU accepts the EXU result this cycle.
- exu_rd  in  5  EXU destination register.
- exu_data  in  XLEN  EXU result.
- lsu_valid  in  1  LSU load result valid.
- lsu_ready  out  1  WBU accepts the LSU result this cycle.
- lsu_rd  in  5  LSU destination register.
- lsu_data  in  XLEN  LSU result.
- rfwen  out  1  register-file write enable.
- w1a  out  5  register-file write address.
- w1d  out  XLEN  register-file write data.
- issue_valid  in  1  IDU issues an instruction that will write issue_rd.
- issue_rd  in  5  destination register of the issuing instruction.
- issue_ready  out  1  scoreboard can record the issue.
- rs1  in  5  first source register queried by the IDU.
- rs2  in  5  second source register queried by the IDU.
- rs1_busy  out  1  rs1 has a pending write.
- rs2_busy  out  1  rs2 has a pending write.
- wb_cnt  out  32  count of accepted results, including writes to x0.

## Operation
- Arbitration:
  - Fixed priority, LSU over EXU.
  - lsu_ready = 1.
  - exu_ready = !lsu_valid.
  - At most one result is accepted per cycle.
- Accept: a source handshakes when valid && ready. On that clock edge:
  - rfwen <= (rd != 0)
  - w1a <= rd
  - w1d <= data
  - wb_cnt <= wb_cnt + 1, wrapping modulo 2^32.
- No accept in a cycle: rfwen <= 0. w1a and w1d hold their previous values.
- Scoreboard: one CNTW-bit counter per register x1..x31. x0 has no counter and always reads 0.
- Increment: when issue_valid && issue_ready && issue_rd != 0.
- Decrement: when rfwen == 1 (the cycle the register file commits), for counter w1a.
- Increment and decrement on the same register in the same cycle leave the counter unchanged.
- issue_ready = (issue_rd == 0) || (count[issue_rd] != 2^CNTW-1). This is combinational and ignores a same-cycle decrement.
- rs1_busy = (count[rs1] != 0), combinational. rs2_busy is the same for rs2. Both are 0 for x0.
- Decrement of a counter already at 0 is a protocol error. The counter holds at 0; the bench flags it.
- Issue with issue_valid && !issue_ready: no counter change. The IDU must hold issue_valid until issue_ready.

## Timing
- Reset (rst_n low, asynchronous) clears:
  - rfwen = 0, w1a = 0, w1d = 0
  - wb_cnt = 0
  - all counters = 0, so rs1_busy = rs2_busy = 0 and issue_ready = 1.
- Reset mid-operation discards all in-flight results and pending counts. A result accepted in the same cycle that reset asserts is lost.
- Latency: handshake at edge N → rfwen/w1a/w1d valid during cycle N..N+1 → register file writes at edge N+1, and the counter decrements at edge N+1.
- rsX_busy deasserts in the cycle after edge N+1. That is the same cycle the register file's combinational read returns the new value, so no bypass is needed.
- Throughput: one writeback per cycle sustained. An EXU result starves only while lsu_valid stays high.
- Sources must hold valid, rd and data stable until ready.

## Test plan
- Reset:
  - Stimulus: drive outputs to arbitrary values, then pulse rst_n low between edges.
  - Required: rfwen = 0, w1a = 0, w1d = 0, wb_cnt = 0, rs1_busy = 0 and issue_ready = 1, immediately and without waiting for a clock edge.
- Single EXU write:
  - Stimulus: issue rd = 5, then EXU valid with rd = 5, data = 0xDEADBEEF.
  - Required: rs1_busy (rs1 = 5) is 1 after the issue. The cycle after the handshake shows rfwen = 1, w1a = 5, w1d = 0xDEADBEEF. Busy is 0 one cycle later. wb_cnt = 1.
- Conflict:
  - Stimulus: lsu_valid and exu_valid both high, rd = 3 and rd = 4.
  - Required: cycle 1 shows exu_ready = 0 and the LSU (x3) is written first. EXU (x4) is written the next cycle. wb_cnt = 2.
- x0 write:
  - Stimulus: EXU result with rd = 0, data = 0x1234.
  - Required: rfwen stays 0, wb_cnt increments, no counter changes.
- Scoreboard saturation (CNTW = 2):
  - Stimulus: issue rd = 7 three times.
  - Required: issue_ready = 0 for rd = 7, and issue_ready = 1 for rd = 8. After one write to x7 commits, issue_ready for rd = 7 returns to 1.
- Simultaneous issue and retire:
  - Stimulus: x9 count = 1; in the same cycle rfwen = 1 with w1a = 9 and an issue of rd = 9.
  - Required: count stays 1 and rs1_busy (rs1 = 9) remains 1.
